// File: rtl/serial_logic_unit.sv
// Bit-serial AND/OR/XOR/ADD stage: LSB-first operand streams in, registered result stream out.
// Serial ADD is built only when SERIAL_LOGIC_UNIT_ADD_EN is defined; otherwise op 11 is reserved.
module serial_logic_unit #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic             a,
  input  logic             b,
  input  logic [1:0]       op,
  input  logic             in_last,
  output logic             out_vld,
  output logic             out_bit,
  output logic             out_last,
  output logic [LEN_W-1:0] out_len,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  state_t           state;
  logic [1:0]       op_q;
  logic [LEN_W-1:0] cnt;
  logic             zero_acc;

  logic             first;
  logic [1:0]       cur_op;
  logic [LEN_W-1:0] new_cnt;
  logic             res;
  logic             zero_nxt;
  logic             trunc;
  logic             word_end;
  logic             op_rsv;
  logic             carry_nxt;

`ifdef SERIAL_LOGIC_UNIT_ADD_EN
  logic carry;
  logic cur_carry;
`endif

  // First bit of a word uses the live op and fresh accumulators instead of the latched ones.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    op_rsv    = 1'b0;
    carry_nxt = 1'b0;
    res       = 1'b0;
    first     = (state == IDLE);
    cur_op    = first ? op : op_q;
    new_cnt   = (first ? '0 : cnt) + LEN_W'(1);
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
    cur_carry = first ? 1'b0 : carry;
`endif
    case (cur_op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      default: begin
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
        res       = a ^ b ^ cur_carry;
        carry_nxt = (a & b) | (cur_carry & (a ^ b));
`else
        op_rsv    = 1'b1;
`endif
      end
    endcase
    zero_nxt = (first | zero_acc) & ~res;
    trunc    = (new_cnt == LEN_W'(MAX_LEN)) && !in_last;
    word_end = in_last || trunc;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_AND;
      cnt       <= '0;
      zero_acc  <= 1'b0;
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
      carry     <= 1'b0;
`endif
      out_vld   <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
      out_len   <= '0;
      out_zero  <= 1'b0;
      out_carry <= 1'b0;
      out_err   <= 1'b0;
    end else if (in_vld) begin
      state     <= word_end ? IDLE : BUSY;
      op_q      <= cur_op;
      cnt       <= new_cnt;
      zero_acc  <= zero_nxt;
`ifdef SERIAL_LOGIC_UNIT_ADD_EN
      carry     <= carry_nxt;
`endif
      out_vld   <= 1'b1;
      out_bit   <= res;
      out_last  <= word_end;
      out_len   <= word_end ? new_cnt : '0;
      out_zero  <= word_end & zero_nxt;
      out_carry <= word_end & carry_nxt;
      out_err   <= word_end & (trunc | op_rsv);
    end else begin
      // Gap cycle: word state holds, output stream idles.
      out_vld   <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
      out_len   <= '0;
      out_zero  <= 1'b0;
      out_carry <= 1'b0;
      out_err   <= 1'b0;
    end
  end

endmodule
